// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the program ROM, and buffers
// {PC, instruction} pairs in a small circular FIFO presented to decode.
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2,
  parameter int              ROM_DEPTH  = 2048
) (
  input  logic            clk,
  input  logic            IF_Rst,
  input  logic            Fetch_Enable,
  input  logic            Redirect_Valid,
  input  logic [XLEN-1:0] Redirect_PC,
  output logic [XLEN-1:0] Rom_Addr,
  output logic            Rom_En,
  input  logic [XLEN-1:0] Rom_Instr,
  output logic            IF_Valid,
  output logic [XLEN-1:0] IF_Instr,
  output logic [XLEN-1:0] IF_PC,
  input  logic            ID_Ready,
  output logic            Fetch_Fault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0]   pc_mem    [FIFO_DEPTH];
  logic [XLEN-1:0]   instr_mem [FIFO_DEPTH];

  logic pop, space, fault_now, issue, fault_set, faulted;

  // Outputs are forced quiet while reset is held, regardless of stored state.
  assign faulted     = (state_q == ST_FAULT);
  assign IF_Valid    = !IF_Rst && (count_q != '0);
  assign IF_Instr    = IF_Rst ? '0 : instr_mem[rd_ptr_q];
  assign IF_PC       = IF_Rst ? '0 : pc_mem[rd_ptr_q];
  assign Fetch_Fault = !IF_Rst && faulted;
  assign Rom_Addr    = pc_q >> 2;
  assign Rom_En      = issue;

  assign pop       = IF_Valid && ID_Ready;
  assign space     = (count_q < CNT_W'(FIFO_DEPTH)) || pop;
  assign fault_now = (pc_q >> 2) >= XLEN'(ROM_DEPTH);
  assign issue     = !IF_Rst && Fetch_Enable && space && !faulted
                     && !fault_now && !Redirect_Valid;
  assign fault_set = Fetch_Enable && space && fault_now && !Redirect_Valid;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    state_d  = state_q;

    if (Redirect_Valid) begin
      // Redirect flushes the buffer and any pop in the same cycle is dropped.
      pc_d     = {Redirect_PC[XLEN-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = ST_RUN;
    end else begin
      if (issue) begin
        pc_d     = pc_q + XLEN'(4);
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({issue, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (fault_set || faulted) begin
        state_d = ST_FAULT;
      end else if (!space || !Fetch_Enable) begin
        state_d = ST_HOLD;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (IF_Rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      state_q  <= ST_RUN;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      state_q  <= state_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; the count and pointers
  // define which entries are meaningful, so clearing the array is wasted logic.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= Rom_Instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a negedge ROM model plus a queue
// of expected {PC, instruction} pairs compared on every accepted decode beat.
module tb_instr_fetch_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            IF_Rst;
  logic            Fetch_Enable;
  logic            Redirect_Valid;
  logic [XLEN-1:0] Redirect_PC;
  logic [XLEN-1:0] Rom_Addr;
  logic            Rom_En;
  logic [XLEN-1:0] Rom_Instr;
  logic            IF_Valid;
  logic [XLEN-1:0] IF_Instr;
  logic [XLEN-1:0] IF_PC;
  logic            ID_Ready;
  logic            Fetch_Fault;

  int n_tests = 0;
  int n_fails = 0;
  int pop_cnt = 0;
  int rom_en_cnt = 0;

  logic [63:0] exp_q [$];
  logic [63:0] exp_e;
  logic [31:0] rom [0:2047];
  logic [31:0] rom_q = '0;

  instr_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2), .ROM_DEPTH(2048)
  ) dut (
    .clk(clk), .IF_Rst(IF_Rst), .Fetch_Enable(Fetch_Enable),
    .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
    .Rom_Addr(Rom_Addr), .Rom_En(Rom_En), .Rom_Instr(Rom_Instr),
    .IF_Valid(IF_Valid), .IF_Instr(IF_Instr), .IF_PC(IF_PC),
    .ID_Ready(ID_Ready), .Fetch_Fault(Fetch_Fault)
  );

  always #5 clk = ~clk;

  assign Rom_Instr = rom_q;

  function automatic logic [31:0] rom_word(input int idx);
    case (idx)
      0:       return 32'hfe010113;
      1:       return 32'h00812e23;
      default: return (32'(idx) * 32'h9E3779B1) ^ 32'h00000013;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({start + 32'(4 * i), rom_word(int'(start >> 2) + i)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ROM samples the address on the negedge inside the issue cycle.
  always @(negedge clk) begin
    if (Rom_En) begin
      rom_q <= (Rom_Addr < 32'd2048) ? rom[Rom_Addr[10:0]] : 32'hBAD0BAD0;
      rom_en_cnt++;
    end
  end

  // Decode-side scoreboard: every accepted beat must match the queue head.
  always @(negedge clk) begin
    if (!IF_Rst && !Redirect_Valid && IF_Valid && ID_Ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        check("pop_extra_pc", {32'b0, IF_PC}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("pop_pc", {32'b0, IF_PC}, {32'b0, exp_e[63:32]});
        check("pop_instr", {32'b0, IF_Instr}, {32'b0, exp_e[31:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = rom_word(i);
    IF_Rst = 1'b1; Fetch_Enable = 1'b1; ID_Ready = 1'b1;
    Redirect_Valid = 1'b0; Redirect_PC = '0;

    // Reset state, then streaming from RESET_PC.
    tick(); tick();
    @(negedge clk);
    check("rst_valid", IF_Valid, 0);
    check("rst_rom_en", Rom_En, 0);
    check("rst_fault", Fetch_Fault, 0);
    check("rst_if_pc", IF_PC, 0);
    check("rst_if_instr", IF_Instr, 0);
    tick(); IF_Rst = 1'b0; expect_seq(32'h0, 20);
    @(negedge clk);
    check("c0_rom_addr", Rom_Addr, 0);
    check("c0_rom_en", Rom_En, 1);
    check("c0_valid", IF_Valid, 0);
    tick(); @(negedge clk);
    check("c1_rom_addr", Rom_Addr, 1);
    check("c1_valid", IF_Valid, 1);
    check("c1_if_pc", IF_PC, 32'h0);
    check("c1_if_instr", IF_Instr, 32'hfe010113);
    tick(); @(negedge clk);
    check("c2_rom_addr", Rom_Addr, 2);
    check("c2_if_pc", IF_PC, 32'h4);
    check("c2_if_instr", IF_Instr, 32'h00812e23);
    repeat (4) tick();

    // Backpressure straight out of reset: exactly two fetches fill the FIFO.
    IF_Rst = 1'b1; ID_Ready = 1'b0;
    tick(); IF_Rst = 1'b0; expect_seq(32'h0, 20); rom_en_cnt = 0;
    repeat (7) tick();
    @(negedge clk);
    check("bp_fetch_count", rom_en_cnt, 2);
    check("bp_rom_en", Rom_En, 0);
    check("bp_valid", IF_Valid, 1);
    check("bp_if_pc_hold", IF_PC, 32'h0);
    tick(); ID_Ready = 1'b1; pop_cnt = 0;
    repeat (6) tick();
    check("bp_drain_pops", pop_cnt, 6);

    // Fetch_Enable low: buffer drains, no new fetches, PC holds.
    Fetch_Enable = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("fe_off_valid", IF_Valid, 0);
    check("fe_off_rom_en", Rom_En, 0);
    tick(); Fetch_Enable = 1'b1;
    repeat (4) tick();

    // Redirect with a full FIFO and decode stalled; low target bits ignored.
    ID_Ready = 1'b0;
    repeat (3) tick();
    Redirect_Valid = 1'b1; Redirect_PC = 32'h42; expect_seq(32'h40, 20);
    tick(); Redirect_Valid = 1'b0;
    @(negedge clk);
    check("rd_valid_after", IF_Valid, 0);
    check("rd_rom_addr", Rom_Addr, 32'h10);
    check("rd_rom_en", Rom_En, 1);
    tick(); @(negedge clk);
    check("rd_first_valid", IF_Valid, 1);
    check("rd_first_pc", IF_PC, 32'h40);
    tick(); ID_Ready = 1'b1;
    repeat (4) tick();

    // Redirect coinciding with a pop from a full FIFO: pop is dropped.
    ID_Ready = 1'b0;
    repeat (3) tick();
    Redirect_Valid = 1'b1; Redirect_PC = 32'h101; ID_Ready = 1'b1;
    expect_seq(32'h100, 20);
    tick(); Redirect_Valid = 1'b0;
    @(negedge clk);
    check("rdpop_valid_after", IF_Valid, 0);
    repeat (5) tick();

    // Run into the top of the ROM: last words drain, then the fault latches.
    Redirect_Valid = 1'b1; Redirect_PC = 32'h1FF8; expect_seq(32'h1FF8, 2);
    tick(); Redirect_Valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("edge_rom_en", Rom_En, 0);
    check("edge_fault_pre", Fetch_Fault, 0);
    tick(); @(negedge clk);
    check("edge_fault", Fetch_Fault, 1);
    check("edge_drained", exp_q.size(), 0);

    // Redirect directly out of range: clears the old fault, then re-faults.
    Redirect_Valid = 1'b1; Redirect_PC = 32'h2000; exp_q.delete();
    tick(); Redirect_Valid = 1'b0; rom_en_cnt = 0;
    @(negedge clk);
    check("oor_fault_clr", Fetch_Fault, 0);
    check("oor_rom_en", Rom_En, 0);
    tick(); @(negedge clk);
    check("oor_fault_set", Fetch_Fault, 1);
    repeat (4) tick();
    @(negedge clk);
    check("oor_fault_sticky", Fetch_Fault, 1);
    check("oor_no_fetch", rom_en_cnt, 0);

    // Redirect back into range resumes fetching.
    Redirect_Valid = 1'b1; Redirect_PC = 32'h0; expect_seq(32'h0, 20);
    tick(); Redirect_Valid = 1'b0;
    @(negedge clk);
    check("resume_fault", Fetch_Fault, 0);
    check("resume_rom_en", Rom_En, 1);
    check("resume_rom_addr", Rom_Addr, 0);
    tick(); @(negedge clk);
    check("resume_valid", IF_Valid, 1);
    check("resume_pc", IF_PC, 32'h0);
    repeat (3) tick();

    // Reset mid-stream with two buffered entries.
    ID_Ready = 1'b0;
    repeat (3) tick();
    IF_Rst = 1'b1; exp_q.delete();
    @(negedge clk);
    check("mrst_valid", IF_Valid, 0);
    check("mrst_fault", Fetch_Fault, 0);
    check("mrst_rom_en", Rom_En, 0);
    tick(); IF_Rst = 1'b0; ID_Ready = 1'b1; expect_seq(32'h0, 20);
    @(negedge clk);
    check("mrst_valid_after", IF_Valid, 0);
    check("mrst_rom_addr", Rom_Addr, 0);
    check("mrst_fault_after", Fetch_Fault, 0);
    tick(); @(negedge clk);
    check("mrst_first_valid", IF_Valid, 1);
    check("mrst_first_pc", IF_PC, 32'h0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
